i2c_bus_fabric: RTL and testbench

I2C_BUS_FABRIC -- requirements
Module: i2c_bus_fabric

---
 rtl/i2c_bus_fabric.sv | 193 +++++++++++++++++++
 tb/tb_i2c_bus_fabric.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_fabric.sv
// i2c_bus_fabric
// Wired-AND I2C bus model for NUM_PORTS open-drain agents, with a passive
// bus monitor: START/STOP detection, byte + ACK capture, per-port
// arbitration-loss flags. Define I2C_BUS_STRETCH_EN to let the fabric stretch
// SCL low for STRETCH_CYCLES clocks after each completed byte; without it
// the stretch logic is absent and stretch_active_o is tied low.
//
// dbg_state_o exposes the monitor FSM (0 = IDLE, 1 = BITS, 2 = ACK).
module i2c_bus_fabric #(
  parameter int NUM_PORTS      = 2,
  parameter int STRETCH_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] scl_o,
  input  logic [NUM_PORTS-1:0] sda_o,
  output logic                 scl_i,
  output logic                 sda_i,
  output logic                 bus_busy_o,
  output logic                 start_o,
  output logic                 stop_o,
  output logic                 byte_valid_o,
  output logic [7:0]           byte_o,
  output logic                 ack_o,
  output logic [NUM_PORTS-1:0] arb_lost_o,
  input  logic [NUM_PORTS-1:0] arb_clr_i,
  output logic                 stretch_active_o,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BITS = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Elaboration-time guard on the supported parameter ranges.
  if (NUM_PORTS < 2 || NUM_PORTS > 8 || STRETCH_CYCLES < 1 || STRETCH_CYCLES > 255) begin : g_param_check
    $error("i2c_bus_fabric: NUM_PORTS or STRETCH_CYCLES out of range");
  end

  state_t                 state;
  state_t                 state_nxt;
  logic                   scl_q;
  logic                   sda_q;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_q;
  logic [NUM_PORTS-1:0]   master_act;
  logic [NUM_PORTS-1:0]   arb_set;
  logic                   stretch_hold;
  logic                   start_det;
  logic                   stop_det;
  logic                   scl_rise;

  // Open-drain pull-up bus: any agent (or the fabric's stretch) pulling low
  // wins. Not gated by reset so the wires stay physical during reset.
  assign sda_i = &sda_o;
  assign scl_i = (&scl_o) & ~stretch_hold;

  // Bus conditions are the live line compared against last cycle's value.
  // START/STOP need SCL high in both samples, so an SCL edge that coincides
  // with an SDA change is only ever seen as an SCL edge.
  assign start_det = scl_q & scl_i &  sda_q & ~sda_i;
  assign stop_det  = scl_q & scl_i & ~sda_q &  sda_i;
  assign scl_rise  = ~scl_q & scl_i;

  assign dbg_state_o = state;

  // Line sample registers used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_i;
      sda_q <= sda_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: STOP beats everything, START restarts a byte from any
  // state, otherwise SCL rising edges walk through 8 data bits and the ACK.
  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = ST_IDLE;
    end else if (start_det) begin
      state_nxt = ST_BITS;
    end else if (scl_rise) begin
      case (state)
        ST_BITS: if (bit_cnt == 3'd7) state_nxt = ST_ACK;
        ST_ACK:  state_nxt = ST_BITS;
        default: state_nxt = state;
      endcase
    end
  end

  // Monitor datapath: bit counter, shifter, byte/ACK capture and pulses.
  // A START clears the counter and shifter, which discards a partial byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_busy_o   <= 1'b0;
      start_o      <= 1'b0;
      stop_o       <= 1'b0;
      byte_valid_o <= 1'b0;
      bit_cnt      <= 3'd0;
      shift_q      <= 8'd0;
      byte_o       <= 8'd0;
      ack_o        <= 1'b1;
    end else begin
      start_o      <= start_det;
      stop_o       <= stop_det;
      byte_valid_o <= 1'b0;
      if (stop_det) begin
        bus_busy_o <= 1'b0;
        bit_cnt    <= 3'd0;
      end else if (start_det) begin
        bus_busy_o <= 1'b1;
        bit_cnt    <= 3'd0;
        shift_q    <= 8'd0;
      end else if (scl_rise) begin
        if (state == ST_BITS) begin
          shift_q <= {shift_q[6:0], sda_i};
          bit_cnt <= bit_cnt + 3'd1;
        end else if (state == ST_ACK) begin
          byte_o       <= shift_q;
          ack_o        <= sda_i;
          byte_valid_o <= 1'b1;
          bit_cnt      <= 3'd0;
        end
      end
    end
  end

  // A port that drives SCL low during a transfer is treated as a master;
  // only masters can lose arbitration. Only data bits count, never the ACK.
  assign arb_set = (scl_rise && state == ST_BITS)
                   ? (master_act & sda_o & {NUM_PORTS{~sda_i}})
                   : '0;

  // Master tracking and sticky arbitration-lost flags (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      master_act <= '0;
      arb_lost_o <= '0;
    end else begin
      if (stop_det) master_act <= '0;
      else          master_act <= master_act | (~scl_o & {NUM_PORTS{bus_busy_o}});
      arb_lost_o <= arb_set | (arb_lost_o & ~arb_clr_i);
    end
  end

`ifdef I2C_BUS_STRETCH_EN
  logic [7:0] stretch_cnt;
  logic       stretch_pend;
  logic       scl_fall;

  assign scl_fall = scl_q & ~scl_i;

  // After a completed byte, arm; the next SCL fall loads the hold counter.
  // The hold ends when the counter drains or on START/STOP/reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stretch_cnt  <= 8'd0;
      stretch_pend <= 1'b0;
    end else if (stop_det || start_det) begin
      stretch_cnt  <= 8'd0;
      stretch_pend <= 1'b0;
    end else begin
      if (stretch_cnt != 8'd0) stretch_cnt <= stretch_cnt - 8'd1;
      if (scl_fall && (stretch_pend || byte_valid_o)) begin
        stretch_cnt  <= 8'(STRETCH_CYCLES);
        stretch_pend <= 1'b0;
      end else if (byte_valid_o) begin
        stretch_pend <= 1'b1;
      end
    end
  end

  // Reset releases the hold immediately, not one clock later.
  assign stretch_hold     = (stretch_cnt != 8'd0) & ~rst;
  assign stretch_active_o = stretch_hold;
`else
  assign stretch_hold     = 1'b0;
  assign stretch_active_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_fabric.sv
// tb_i2c_bus_fabric
// Directed bench for i2c_bus_fabric with two agents. Agents are driven from
// tasks; one-cycle pulses are counted by a negedge monitor and compared
// with hand-computed expectations.
module tb_i2c_bus_fabric;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] scl_o;
  logic [N-1:0] sda_o;
  logic         scl_i;
  logic         sda_i;
  logic         bus_busy_o;
  logic         start_o;
  logic         stop_o;
  logic         byte_valid_o;
  logic [7:0]   byte_o;
  logic         ack_o;
  logic [N-1:0] arb_lost_o;
  logic [N-1:0] arb_clr_i;
  logic         stretch_active_o;
  logic [1:0]   dbg_state_o;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  int         start_seen   = 0;
  int         stop_seen    = 0;
  int         bv_seen      = 0;
  int         stretch_seen = 0;
  int         stretch_high = 0;
  logic [7:0] last_byte    = 8'h00;
  logic       last_ack     = 1'b1;

  logic [7:0] d0;
  logic [7:0] d1;

  i2c_bus_fabric #(.NUM_PORTS(N), .STRETCH_CYCLES(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .scl_o            (scl_o),
    .sda_o            (sda_o),
    .scl_i            (scl_i),
    .sda_i            (sda_i),
    .bus_busy_o       (bus_busy_o),
    .start_o          (start_o),
    .stop_o           (stop_o),
    .byte_valid_o     (byte_valid_o),
    .byte_o           (byte_o),
    .ack_o            (ack_o),
    .arb_lost_o       (arb_lost_o),
    .arb_clr_i        (arb_clr_i),
    .stretch_active_o (stretch_active_o),
    .dbg_state_o      (dbg_state_o)
  );

  // Clock.
  always #5 clk = ~clk;

  // Pulse / stretch monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (start_o) start_seen++;
    if (stop_o)  stop_seen++;
    if (byte_valid_o) begin
      bv_seen++;
      last_byte = byte_o;
      last_ack  = ack_o;
    end
    if (stretch_active_o) begin
      stretch_seen++;
      if (scl_i) stretch_high++;
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Release SCL and wait (bounded) for the line to actually go high.
  task automatic release_scl();
    int w;
    scl_o = '1;
    cyc(1);
    w = 0;
    while (!scl_i && w < 40) begin
      cyc(1);
      w++;
    end
    if (!scl_i) check("scl_release_timeout", scl_i, 1'b1);
    cyc(1);
  endtask

  // START (or repeated START) driven by the ports in 'who'.
  task automatic bus_start(input logic [N-1:0] who);
    sda_o = '1;
    cyc(2);
    release_scl();
    sda_o = ~who;
    cyc(2);
    scl_o = ~who;
    cyc(2);
  endtask

  // One SCL clock with SDA set up while SCL is low.
  task automatic clock_bit(input logic [N-1:0] sda_v, input logic [N-1:0] masters);
    sda_o = sda_v;
    cyc(2);
    release_scl();
    scl_o = ~masters;
    cyc(2);
  endtask

  // Eight data bits from master set m plus an ACK bit pulled by 'acker'.
  task automatic send_byte(input logic [N-1:0] m, input logic [7:0] d, input logic [N-1:0] acker);
    for (int i = 7; i >= 0; i--) clock_bit(d[i] ? '1 : ~m, m);
    clock_bit(~acker, m);
  endtask

  task automatic bus_stop(input logic [N-1:0] who);
    sda_o = ~who;
    cyc(2);
    release_scl();
    sda_o = '1;
    cyc(2);
  endtask

  initial begin
    rst       = 1'b1;
    scl_o     = '1;
    sda_o     = '1;
    arb_clr_i = '0;
    cyc(3);

    // Reset values.
    check("rst_busy",    bus_busy_o,       1'b0);
    check("rst_byte",    byte_o,           8'h00);
    check("rst_ack",     ack_o,            1'b1);
    check("rst_arb",     arb_lost_o,       2'b00);
    check("rst_stretch", stretch_active_o, 1'b0);
    check("rst_state",   dbg_state_o,      2'd0);

    // Resolution is live during reset.
    sda_o = 2'b01;
    scl_o = 2'b10;
    cyc(1);
    check("rst_sda_resolve", sda_i, 1'b0);
    check("rst_scl_resolve", scl_i, 1'b0);
    sda_o = '1;
    scl_o = '1;
    cyc(1);
    rst = 1'b0;
    cyc(2);

    // SCL and SDA falling then rising together: no START, no STOP.
    scl_o = 2'b10;
    sda_o = 2'b10;
    cyc(2);
    scl_o = '1;
    sda_o = '1;
    cyc(2);
    check("simul_no_start", start_seen, 0);
    check("simul_no_stop",  stop_seen,  0);
    check("simul_idle",     bus_busy_o, 1'b0);

    // Single write 0xA4, port1 ACKs.
    bus_start(2'b01);
    check("wr_start_pulse", start_seen,  1);
    check("wr_busy",        bus_busy_o,  1'b1);
    check("wr_state_bits",  dbg_state_o, 2'd1);
    send_byte(2'b01, 8'hA4, 2'b10);
    check("wr_bv",   bv_seen,   1);
    check("wr_byte", last_byte, 8'hA4);
    check("wr_ack",  last_ack,  1'b0);
    bus_stop(2'b01);
    check("wr_stop_pulse", stop_seen,   1);
    check("wr_busy_off",   bus_busy_o,  1'b0);
    check("wr_state_idle", dbg_state_o, 2'd0);
`ifdef I2C_BUS_STRETCH_EN
    check("wr_stretch_len",  stretch_seen, 8);
    check("wr_stretch_held", stretch_high, 0);
`endif

    // Arbitration: port0 0x50 (0101_0000) vs port1 0x40 (0100_0000);
    // they first differ on the 4th transmitted bit, where port0 loses.
    d0 = 8'h50;
    d1 = 8'h40;
    bus_start(2'b11);
    for (int i = 7; i >= 5; i--) clock_bit({d1[i], d0[i]}, 2'b11);
    check("arb_before", arb_lost_o, 2'b00);
    clock_bit({d1[4], d0[4]}, 2'b11);
    check("arb_lost_p0", arb_lost_o, 2'b01);
    arb_clr_i = 2'b01;
    cyc(1);
    arb_clr_i = 2'b00;
    check("arb_cleared", arb_lost_o, 2'b00);
    for (int i = 3; i >= 0; i--) clock_bit({d1[i], d0[i]}, 2'b11);
    // ACK from port1 while master port0 releases SDA: no flag in ACK.
    clock_bit(2'b01, 2'b11);
    check("arb_not_in_ack", arb_lost_o, 2'b00);
    check("arb_bv",   bv_seen,   2);
    check("arb_byte", last_byte, 8'h40);
    check("arb_ack",  last_ack,  1'b0);
    bus_stop(2'b11);
    check("arb_stop", stop_seen, 2);

    // Repeated START after 4 bits, then a full 0x3C.
    bus_start(2'b01);
    clock_bit(2'b11, 2'b01);
    clock_bit(2'b10, 2'b01);
    clock_bit(2'b11, 2'b01);
    clock_bit(2'b10, 2'b01);
    bus_start(2'b01);
    check("rs_start_pulse", start_seen, 4);
    check("rs_no_bv",       bv_seen,    2);
    send_byte(2'b01, 8'h3C, 2'b10);
    check("rs_bv",   bv_seen,   3);
    check("rs_byte", last_byte, 8'h3C);
    check("rs_ack",  last_ack,  1'b0);

    // NACK on 0xFF.
    send_byte(2'b01, 8'hFF, 2'b00);
    check("nack_bv",   bv_seen,   4);
    check("nack_byte", last_byte, 8'hFF);
    check("nack_ack",  last_ack,  1'b1);
    bus_stop(2'b01);
    check("nack_stop", stop_seen,  3);
    check("nack_idle", bus_busy_o, 1'b0);

    // Reset at bit 5, then a normal transfer.
    bus_start(2'b01);
    check("mr_start", start_seen, 5);
    clock_bit(2'b11, 2'b01);
    clock_bit(2'b11, 2'b01);
    clock_bit(2'b10, 2'b01);
    clock_bit(2'b11, 2'b01);
    clock_bit(2'b10, 2'b01);
    check("mr_state_bits", dbg_state_o, 2'd1);
    rst = 1'b1;
    cyc(1);
    check("mr_busy",    bus_busy_o,       1'b0);
    check("mr_byte",    byte_o,           8'h00);
    check("mr_ack",     ack_o,            1'b1);
    check("mr_state",   dbg_state_o,      2'd0);
    check("mr_arb",     arb_lost_o,       2'b00);
    check("mr_stretch", stretch_active_o, 1'b0);
    sda_o = '1;
    cyc(1);
    scl_o = '1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    check("mr_no_bv", bv_seen, 4);
    bus_start(2'b01);
    check("mr_restart", start_seen, 6);
    check("mr_busy_on", bus_busy_o, 1'b1);
    send_byte(2'b01, 8'h81, 2'b10);
    check("mr_bv",       bv_seen,   5);
    check("mr_byte_new", last_byte, 8'h81);
    check("mr_ack_new",  last_ack,  1'b0);
    bus_stop(2'b01);
    check("mr_stop", stop_seen, 4);

`ifdef I2C_BUS_STRETCH_EN
    // Five completed bytes, each followed by an SCL fall: 5 x 8 cycles.
    check("stretch_total",     stretch_seen, 40);
    check("stretch_scl_held",  stretch_high, 0);
`else
    check("stretch_tied_low", stretch_seen, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
